bm_dag3_log_rx: RTL
===================

BM_DAG3_LOG_RX -- requirements
Module: bm_dag3_log_rx

Interface
REQ-001 Parameter BITS, default 2, SHALL set the symbol width in bits.
REQ-002 Parameter SYMS, default 4, SHALL set the number of symbols packed per word; word width W = BITS*SYMS = 8.
REQ-003 Parameter DEPTH, default 4, SHALL set the FIFO depth in words; power of two only.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports `clock` and `resetn`.
REQ-005 Port clock, input, 1: the only clock; all state SHALL update on the rising edge.
REQ-006 Port resetn, input, 1: asynchronous, active-low reset.
REQ-007 Port sym_in, input, BITS: incoming symbol, sampled only when sym_valid=1.
REQ-008 Port sym_valid, input, 1: sym_in is valid this cycle.
REQ-009 Port rd_en, input, 1: pop request for the FIFO head.
REQ-010 Port word_out, output, W: last popped word, registered.
REQ-011 Port word_valid, output, 1: word_out was updated by the previous edge; 1-cycle pulse.
REQ-012 Port word_par, output, 1: XOR of all bits of word_out, registered with word_out.
REQ-013 Port full, output, 1: count == DEPTH.
REQ-014 Port empty, output, 1: count == 0.
REQ-015 Port count, output, log2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
REQ-016 Port overflow, output, 1: sticky flag, set when a completed word is dropped.

Function
REQ-017 The assembler SHALL hold a symbol index idx (0..SYMS-1) and a W-bit shift buffer.
REQ-018 On an edge with sym_valid=1, sym_in SHALL be written to buffer bits [BITS*idx+BITS-1 : BITS*idx], and idx SHALL increment.
REQ-019 With sym_valid=1 and idx=SYMS-1, the completed word (buffer with the final symbol merged) SHALL be pushed on that same edge, and idx SHALL wrap to 0.
REQ-020 With sym_valid=0, idx and the buffer SHALL hold.
REQ-021 Push rule: the write SHALL be accepted if full=0, or if full=1 and a pop occurs on the same edge.
  - Otherwise the word SHALL be dropped and overflow SHALL be set to 1.
  - A dropped word SHALL NOT alter the FIFO contents.
REQ-022 Pop rule: rd_en=1 with empty=0 (evaluated before the edge) SHALL load the head into word_out, load its parity into word_par, set word_valid=1 for one cycle, and advance the read pointer.
REQ-023 rd_en=1 with empty=1 SHALL be ignored: word_out and word_par hold, word_valid=0, and no error is flagged.
  - A push on that same edge SHALL still be accepted.
REQ-024 On a simultaneous accepted push and pop, count SHALL be unchanged.
  - push only: count +1.
  - pop only: count -1.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 The FIFO SHALL be first-in first-out, with no reordering.
REQ-027 Minimum latency from the edge accepting the last symbol to word_valid=1 SHALL be 2 edges (the push edge, then the pop edge with rd_en asserted in the intervening cycle).
REQ-028 full, empty, and count SHALL be derived from registered state only, with no combinational path from sym_valid or rd_en.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 While resetn=0, all state SHALL be cleared asynchronously: idx=0, buffer=0, pointers=0, count=0, word_out=0, word_par=0, word_valid=0, overflow=0, empty=1, full=0.
REQ-031 FIFO storage contents need not be cleared, but they SHALL be unobservable until written.
REQ-032 Reset asserted mid-word SHALL discard the partial word.
  - The first symbol after deassertion SHALL land in bits [1:0].
REQ-033 The first edge after resetn deasserts SHALL operate normally.

Verification
REQ-034 Reset, then symbols 1,2,3,0 on consecutive cycles, then rd_en for 1 cycle -> count goes 0->1 on the 4th-symbol edge; word_out=8'h39, word_par=0, word_valid pulses once, count returns to 0.
REQ-035 Push 4 words 8'h00,8'h55,8'hAA,8'hFF -> full=1, count=4; pop 4 times -> outputs appear in that order with word_par=0 for each; empty=1 afterwards.
REQ-036 FIFO full, 5th word completes with rd_en=0 -> overflow=1, count stays 4, the pops return the original 4 words only.
REQ-037 FIFO full, 5th word completes on the same edge as a pop -> overflow=0, count=4; the 5th word is returned last.
REQ-038 FIFO empty, rd_en=1 on the edge the 4th symbol is accepted -> no word_valid that edge, count=1; the next rd_en returns the word.
REQ-039 Two symbols sent, resetn pulsed low mid-cycle (asynchronous), then symbols 3,3,3,3 -> outputs zero immediately on assertion; the next pop yields 8'hFF with word_par=0 and overflow=0.

Source files
------------

// File: rtl/bm_dag3_log_rx.sv
// Symbol receiver: packs BITS-wide symbols into W-bit words and queues
// them in a DEPTH-word FIFO with a registered pop port and parity.
module bm_dag3_log_rx #(
    parameter int BITS  = 2,
    parameter int SYMS  = 4,
    parameter int DEPTH = 4,
    localparam int W    = BITS * SYMS,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int IW   = (SYMS > 1) ? $clog2(SYMS) : 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [BITS-1:0] sym_in,
    input  logic            sym_valid,
    input  logic            rd_en,
    output logic [W-1:0]    word_out,
    output logic            word_valid,
    output logic            word_par,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count,
    output logic            overflow
);

    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_q, out_d;
    logic          par_q, par_d;
    logic          vld_q, vld_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic [W-1:0]  merged;
    logic          word_done;
    logic          pop;
    logic          push;
    logic          drop;
    logic          full_w;
    logic          empty_w;

    assign full_w  = (cnt_q == CW'(DEPTH));
    assign empty_w = (cnt_q == '0);

    // Current buffer with the incoming symbol dropped into its slot
    always_comb begin
        merged = buf_q;
        for (int s = 0; s < SYMS; s++) begin
            if (idx_q == IW'(s)) begin
                merged[s*BITS +: BITS] = sym_in;
            end
        end
    end

    assign word_done = sym_valid && (idx_q == IW'(SYMS - 1));
    assign pop       = rd_en && !empty_w;
    assign push      = word_done && (!full_w || pop);
    assign drop      = word_done && !push;

    always_comb begin
        idx_d = idx_q;
        buf_d = buf_q;
        if (sym_valid) begin
            buf_d = merged;
            if (idx_q == IW'(SYMS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        par_d    = par_q;
        vld_d    = 1'b0;
        ovf_d    = ovf_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            out_d    = mem_q[rd_ptr_q];
            par_d    = ^mem_q[rd_ptr_q];
            vld_d    = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx_q    <= '0;
            buf_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            par_q    <= 1'b0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            par_q    <= par_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never read before written, so it carries no reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= merged;
        end
    end

    assign word_out   = out_q;
    assign word_par   = par_q;
    assign word_valid = vld_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign count      = cnt_q;
    assign overflow   = ovf_q;

endmodule
